// File: rtl/card_shoe.sv
// Card shoe: fills an N-card rank store, shuffles it in place with a Fisher-Yates
// walk driven by a free-running LFSR, then deals one card value per request.
module card_shoe #(
  parameter int          NUM_DECKS = 1,
  parameter int          CUT_CARDS = 13,
  parameter logic [15:0] SEED      = 16'hACE1,
  localparam int         N         = 52 * NUM_DECKS,
  localparam int         CNT_W     = $clog2(N + 1)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             shuffle_req,
  input  logic             card_req,
  output logic             card_valid,
  output logic [3:0]       card_out,
  output logic             shuffle_ok,
  output logic             busy,
  output logic             empty,
  output logic             reshuffle,
  output logic [CNT_W-1:0] cards_left
);

  // state   | meaning
  // IDLE    | after reset, no deck available
  // INIT    | writing rank k mod 13 into entry k, one entry per cycle
  // SHUFFLE | Fisher-Yates walk from i=N-1 down to i=1
  // READY   | dealing cards from ptr upward
  typedef enum logic [1:0] {IDLE, INIT, SHUFFLE, READY} state_t;

  localparam logic [CNT_W-1:0] LAST   = CNT_W'(N - 1);
  localparam logic [CNT_W-1:0] FULL   = CNT_W'(N);
  localparam logic [CNT_W-1:0] CUT    = CNT_W'(CUT_CARDS);
  localparam logic [CNT_W-1:0] ONE    = CNT_W'(1);

  state_t           state_q, state_d;
  logic [15:0]      lfsr_q, lfsr_d;
  logic [CNT_W-1:0] idx_q, idx_d;
  logic [3:0]       rank_q, rank_d;
  logic [CNT_W-1:0] ptr_q, ptr_d;
  logic [CNT_W-1:0] left_q, left_d;
  logic             card_valid_q, card_valid_d;
  logic [3:0]       card_out_q, card_out_d;
  logic             shuffle_ok_q, shuffle_ok_d;
  logic [3:0]       mem_q [N];
  logic [3:0]       mem_d [N];

  logic [CNT_W-1:0] j_mask;
  logic [CNT_W-1:0] j;
  logic             swap_ok;

  function automatic logic [3:0] rank_value(input logic [3:0] r);
    return (r <= 4'd9) ? r + 4'd1 : 4'd11;
  endfunction

  // j is the LFSR trimmed to the bit length of i; values above i are retried.
  always_comb begin
    j_mask = '0;
    for (int b = 0; b < CNT_W; b++) j_mask[b] = |(idx_q >> b);
    j       = lfsr_q[CNT_W-1:0] & j_mask;
    swap_ok = (j <= idx_q);
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (shuffle_req) state_d = INIT;
      INIT:    if (idx_q == LAST) state_d = SHUFFLE;
      SHUFFLE: if (swap_ok && idx_q == ONE) state_d = READY;
      READY:   if (shuffle_req) state_d = INIT;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    lfsr_d       = {1'b0, lfsr_q[15:1]} ^ (lfsr_q[0] ? 16'hB400 : 16'h0000);
    idx_d        = idx_q;
    rank_d       = rank_q;
    ptr_d        = ptr_q;
    left_d       = left_q;
    card_valid_d = 1'b0;
    card_out_d   = card_out_q;
    shuffle_ok_d = 1'b0;
    mem_d        = mem_q;
    case (state_q)
      IDLE: begin
        if (shuffle_req) begin
          idx_d  = '0;
          rank_d = '0;
        end
      end
      INIT: begin
        mem_d[idx_q] = rank_q;
        rank_d       = (rank_q == 4'd12) ? 4'd0 : rank_q + 4'd1;
        if (idx_q != LAST) idx_d = idx_q + ONE;
      end
      SHUFFLE: begin
        if (swap_ok) begin
          mem_d[idx_q] = mem_q[j];
          mem_d[j]     = mem_q[idx_q];
          idx_d        = idx_q - ONE;
          if (idx_q == ONE) begin
            shuffle_ok_d = 1'b1;
            left_d       = FULL;
            ptr_d        = '0;
          end
        end
      end
      READY: begin
        if (shuffle_req) begin
          idx_d  = '0;
          rank_d = '0;
          ptr_d  = '0;
          left_d = '0;
        end else if (card_req && left_q != '0) begin
          card_valid_d = 1'b1;
          card_out_d   = rank_value(mem_q[ptr_q]);
          ptr_d        = ptr_q + ONE;
          left_d       = left_q - ONE;
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q      <= IDLE;
      lfsr_q       <= SEED;
      idx_q        <= '0;
      rank_q       <= '0;
      ptr_q        <= '0;
      left_q       <= '0;
      card_valid_q <= 1'b0;
      card_out_q   <= '0;
      shuffle_ok_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      lfsr_q       <= lfsr_d;
      idx_q        <= idx_d;
      rank_q       <= rank_d;
      ptr_q        <= ptr_d;
      left_q       <= left_d;
      card_valid_q <= card_valid_d;
      card_out_q   <= card_out_d;
      shuffle_ok_q <= shuffle_ok_d;
    end
  end

  // Store contents are meaningless until INIT rewrites them, so no reset here.
  always_ff @(posedge clk) begin
    mem_q <= mem_d;
  end

  always_comb begin
    busy       = (state_q == INIT) || (state_q == SHUFFLE);
    reshuffle  = (state_q == READY) && (left_q <= CUT);
    empty      = (left_q == '0);
    card_valid = card_valid_q;
    card_out   = card_out_q;
    shuffle_ok = shuffle_ok_q;
    cards_left = left_q;
  end

endmodule

// File: tb/tb_card_shoe.sv
// Bench for card_shoe: scoreboarded single-deck deals, cut-card, ignored requests,
// mid-shuffle reset, and a two-deck determinism check.
module tb_card_shoe;

  logic       clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst1, shuf1, creq1;
  logic       valid1, ok1, busy1, empty1, resh1;
  logic [3:0] out1;
  logic [5:0] left1;

  logic       rst2, shuf2, creq2;
  logic       valid2, ok2, busy2, empty2, resh2;
  logic [3:0] out2;
  logic [6:0] left2;

  card_shoe u_dut1 (
    .clk(clk), .reset(rst1), .shuffle_req(shuf1), .card_req(creq1),
    .card_valid(valid1), .card_out(out1), .shuffle_ok(ok1), .busy(busy1),
    .empty(empty1), .reshuffle(resh1), .cards_left(left1)
  );

  card_shoe #(.NUM_DECKS(2)) u_dut2 (
    .clk(clk), .reset(rst2), .shuffle_req(shuf2), .card_req(creq2),
    .card_valid(valid2), .card_out(out2), .shuffle_ok(ok2), .busy(busy2),
    .empty(empty2), .reshuffle(resh2), .cards_left(left2)
  );

  typedef struct {
    int cyc;
    int left;
  } exp_t;

  exp_t       sb_q [$];
  int         n_tests = 0;
  int         n_fail  = 0;
  int         cyc     = 0;
  int         model_left  = 0;
  bit         model_ready = 1'b0;
  int         n_valid1 = 0;
  int         ok_cnt1  = 0;
  int         hist1 [16];
  logic [3:0] seq1 [52];
  logic [3:0] seq2 [2][104];
  int         cnt2 [2];

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (ok1 === 1'b1) ok_cnt1++;
    if (valid1 === 1'b1) begin
      if (n_valid1 < 52) seq1[n_valid1] = out1;
      n_valid1++;
      hist1[out1]++;
      check("reshuffle_vs_left", resh1, (left1 <= 13));
      if (sb_q.size() == 0) check("unexpected_valid", 1, 0);
      else begin
        exp_t e;
        e = sb_q.pop_front();
        check("valid_latency", cyc, e.cyc);
        check("left_after_deal", left1, e.left);
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Hold card_req for n cycles; every request the model says is serviceable is scoreboarded.
  task automatic deal1(input int n);
    for (int k = 0; k < n; k++) begin
      creq1 = 1'b1;
      if (model_ready && model_left > 0 && !shuf1) begin
        exp_t e;
        e.cyc  = cyc + 1;
        e.left = model_left - 1;
        sb_q.push_back(e);
        model_left--;
      end
      step();
    end
    creq1 = 1'b0;
  endtask

  task automatic wait_ok1(output bit seen);
    seen = 1'b0;
    for (int n = 0; n < 20 * 52; n++) begin
      @(negedge clk);
      if (ok1) begin
        seen = 1'b1;
        break;
      end
    end
    step();
  endtask

  task automatic run2(input int r);
    bit seen;
    cnt2[r] = 0;
    rst2 = 1'b0;
    step(); step();
    rst2 = 1'b1;
    step();
    shuf2 = 1'b1;
    step();
    shuf2 = 1'b0;
    seen = 1'b0;
    for (int n = 0; n < 20 * 104; n++) begin
      @(negedge clk);
      if (ok2) begin
        seen = 1'b1;
        break;
      end
    end
    check("deck2_shuffle_ok", seen, 1);
    creq2 = 1'b1;
    for (int k = 0; k < 108; k++) begin
      @(negedge clk);
      if (valid2) begin
        if (cnt2[r] < 104) seq2[r][cnt2[r]] = out2;
        cnt2[r]++;
      end
    end
    creq2 = 1'b0;
    check("deck2_card_count", cnt2[r], 104);
  endtask

  initial begin
    bit seen;
    int n_same;
    int n_diff;
    int h2 [16];
    logic [3:0] v;

    for (int i = 0; i < 16; i++) hist1[i] = 0;
    rst1 = 1'b0; shuf1 = 1'b1; creq1 = 1'b0;
    rst2 = 1'b0; shuf2 = 1'b0; creq2 = 1'b0;

    // Reset with shuffle_req held high.
    step();
    check("rst_valid", valid1, 0);
    check("rst_card_out", out1, 0);
    check("rst_shuffle_ok", ok1, 0);
    check("rst_busy", busy1, 0);
    check("rst_reshuffle", resh1, 0);
    check("rst_left", left1, 0);
    check("rst_empty", empty1, 1);
    step();
    check("rst_busy_2nd", busy1, 0);
    rst1 = 1'b1; shuf1 = 1'b0;
    step();
    check("idle_after_rst", busy1, 0);

    // Card requests while IDLE produce nothing.
    deal1(3);
    step();
    check("idle_req_no_valid", n_valid1, 0);
    check("idle_req_left", left1, 0);

    // Shuffle, with shuffle_req and card_req thrown in during SHUFFLE.
    ok_cnt1 = 0;
    shuf1 = 1'b1;
    step();
    shuf1 = 1'b0;
    check("busy_in_init", busy1, 1);
    repeat (60) step();
    check("busy_in_shuffle", busy1, 1);
    shuf1 = 1'b1;
    deal1(8);
    shuf1 = 1'b0;
    check("no_valid_while_busy", n_valid1, 0);
    wait_ok1(seen);
    check("shuffle_ok_seen", seen, 1);
    check("ready_left", left1, 52);
    check("ready_busy", busy1, 0);
    check("ready_empty", empty1, 0);
    check("ready_reshuffle", resh1, 0);
    model_left  = 52;
    model_ready = 1'b1;

    // Cut card boundary then deal to exhaustion plus one extra request.
    deal1(38);
    @(negedge clk);
    check("left_at_14", left1, 14);
    check("resh_at_14", resh1, 0);
    step();
    deal1(1);
    @(negedge clk);
    check("left_at_13", left1, 13);
    check("resh_at_13", resh1, 1);
    step();
    deal1(14);
    repeat (3) step();
    check("total_strobes", n_valid1, 52);
    check("final_left", left1, 0);
    check("final_empty", empty1, 1);
    check("final_reshuffle", resh1, 1);
    check("sb_drained", sb_q.size(), 0);
    check("shuffle_ok_once", ok_cnt1, 1);
    for (int val = 1; val <= 11; val++)
      check($sformatf("hist1_val%0d", val), hist1[val], (val == 11) ? 12 : 4);
    n_same = 0;
    for (int k = 0; k < 52; k++) begin
      v = ((k % 13) <= 9) ? 4'((k % 13) + 1) : 4'd11;
      if (seq1[k] == v) n_same++;
    end
    check("deck_is_shuffled", (n_same == 52), 0);

    // Reset in the middle of SHUFFLE, then a clean reshuffle.
    ok_cnt1 = 0;
    shuf1 = 1'b1;
    step();
    shuf1 = 1'b0;
    model_left = 0; model_ready = 1'b0;
    repeat (70) step();
    check("busy_before_abort", busy1, 1);
    rst1 = 1'b0;
    step();
    rst1 = 1'b1;
    check("abort_busy", busy1, 0);
    check("abort_left", left1, 0);
    check("abort_empty", empty1, 1);
    step();
    shuf1 = 1'b1;
    step();
    shuf1 = 1'b0;
    wait_ok1(seen);
    check("reshuffle_ok_seen", seen, 1);
    check("reshuffle_left", left1, 52);
    check("reshuffle_ok_count", ok_cnt1, 1);
    model_left = 52; model_ready = 1'b1;
    deal1(5);
    step();
    check("after_5_left", left1, 47);
    check("sb_drained_2", sb_q.size(), 0);

    // Two-deck determinism.
    run2(0);
    run2(1);
    n_diff = 0;
    for (int i = 0; i < 16; i++) h2[i] = 0;
    for (int k = 0; k < 104; k++) begin
      if (seq2[0][k] !== seq2[1][k]) n_diff++;
      h2[seq2[0][k]]++;
    end
    check("deck2_same_sequence", n_diff, 0);
    for (int val = 1; val <= 11; val++)
      check($sformatf("hist2_val%0d", val), h2[val], (val == 11) ? 24 : 8);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/card_shoe.md
CARD_SHOE -- requirements
Module: card_shoe

Interface
REQ-001 SHALL have parameter NUM_DECKS, default 1, number of 52-card decks in the shoe (legal range 1..8).
REQ-002 SHALL have parameter CUT_CARDS, default 13, remaining-card count at or below which reshuffle asserts.
REQ-003 SHALL have parameter SEED, default 16'hACE1, non-zero LFSR reset value.
REQ-004 SHALL derive the following quantities from the parameters: N = 52*NUM_DECKS; CNT_W = $clog2(N+1).
REQ-005 SHALL have port clk  in  1  the single clock; all logic on its rising edge.
REQ-006 SHALL have port reset  in  1  synchronous, active-low reset.
REQ-007 SHALL have port shuffle_req  in  1  level sampled each cycle; requests a full fill and shuffle.
REQ-008 SHALL have port card_req  in  1  requests one card this cycle.
REQ-009 SHALL have port card_valid  out  1  one-cycle strobe; card_out is valid.
REQ-010 SHALL have port card_out  out  4  card value, 1..11.
REQ-011 SHALL have port shuffle_ok  out  1  one-cycle pulse when the shoe becomes ready.
REQ-012 SHALL have port busy  out  1  high in INIT and SHUFFLE.
REQ-013 SHALL have port empty  out  1  high when cards_left == 0.
REQ-014 SHALL have port reshuffle  out  1  high in READY when cards_left <= CUT_CARDS.
REQ-015 SHALL have port cards_left  out  CNT_W  number of undealt cards.

Function
REQ-016 SHALL use an N-entry, 4-bit rank store (0..12) and map ranks to values: rank r<=9 gives r+1; ranks 10, 11 and 12 give 11.
REQ-017 SHALL use a 16-bit Galois LFSR (x^16+x^14+x^13+x^11+1) that advances every cycle in every state.
REQ-018 SHALL implement states IDLE, INIT, SHUFFLE and READY.
REQ-019 SHALL move IDLE or READY to INIT on the cycle after shuffle_req=1; shuffle_req takes priority over card_req in the same cycle.
REQ-020 In INIT, SHALL write entry k with rank k mod 13, one entry per cycle, for N cycles, then go to SHUFFLE with index i=N-1.
REQ-021 In SHUFFLE (Fisher-Yates), each cycle SHALL draw j = LFSR masked to $clog2(i+1) bits:
- if j <= i: swap entries i and j in that cycle, then decrement i;
- if j > i: retry on the next cycle with i unchanged.
REQ-022 When the SHUFFLE step at i=1 completes, SHALL go to READY, pulse shuffle_ok for 1 cycle, and set cards_left=N and read pointer=0.
REQ-023 In READY with card_req=1 and cards_left>0, on the next cycle SHALL drive card_valid=1 and card_out=value(entry[ptr]), and SHALL increment ptr and decrement cards_left.
REQ-024 SHALL accept back-to-back requests, one card per cycle.
REQ-025 card_req with cards_left==0, or in IDLE, INIT or SHUFFLE, SHALL produce no card_valid and no state change.
REQ-026 shuffle_req while busy SHALL be ignored; the current shuffle continues undisturbed.
REQ-027 SHALL never let cards_left wrap below 0 or exceed N.
REQ-028 card_out SHALL hold its last value when card_valid=0.
REQ-029 For a given SEED and a given request timing, the dealt sequence SHALL be deterministic.

Reset
REQ-030 With reset=0 at a clock edge, SHALL enter IDLE and drive outputs:
- card_valid=0, card_out=0, shuffle_ok=0, busy=0, reshuffle=0;
- cards_left=0, empty=1.
REQ-031 On the same reset edge, SHALL load SEED into the LFSR and clear ptr.
REQ-032 Reset in any state, including mid-INIT or mid-SHUFFLE, SHALL abort the operation; the store contents are don't-care until the next INIT.

Verification
REQ-033 Reset scenario: hold reset=0 for 2 cycles -> outputs as in REQ-030 on the first edge; shuffle_req while reset=0 is ignored.
REQ-034 Single-deck deal: NUM_DECKS=1, pulse shuffle_req, then hold card_req high for 53 cycles ->
- shuffle_ok within 20*N cycles;
- exactly 52 card_valid strobes, with values 1..10 four times each and 11 twelve times;
- empty=1 and no 53rd strobe.
REQ-035 Cut card: deal 39 cards -> reshuffle rises on the cycle cards_left reaches 13 and stays high through empty.
REQ-036 Ignored requests: shuffle_req and card_req during SHUFFLE -> no card_valid, no restart; shuffle_ok occurs exactly once.
REQ-037 Reset mid-operation: reset=0 mid-SHUFFLE -> IDLE, busy=0, cards_left=0; a new shuffle_req then completes normally.
REQ-038 Two-deck determinism: NUM_DECKS=2, two runs with the same SEED and identical timing ->
- identical 104-card sequences;
- value 11 appears 24 times; every other value appears 8 times.
